card_deck: RTL

Single-deck card source for the blackjack datapath. Sits directly upstream of the game controller and supplies one card per request from a 52-card deck drawn without replacement. Card order comes from a free-running LFSR. Each delivered card carries its blackjack value (ace = 11, face = 10) on a 6-bit bus that matches the score width.

---
 rtl/card_deck.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/card_deck.sv
`default_nettype none
// ============================================================================
// card_deck : 52-card single deck, one card per draw, drawn without
//             replacement in LFSR order. Build option CARD_DECK_FIXED_SEQ_EN
//             replaces LFSR/used mask with a 16-entry fixed card ROM.
// Rev 1.0
// ============================================================================
module card_deck #(
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int unsigned LOW_WATER = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       shuffle,
   input  logic       draw_req,
   output logic       busy,
   output logic       card_valid,
   output logic [5:0] card_value,
   output logic [3:0] card_rank,
   output logic [1:0] card_suit,
   output logic [5:0] cards_left,
   output logic       deck_empty,
   output logic       low_cards,
   output logic       draw_err
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_SCAN   = 1'b1;
   localparam logic [5:0] DECK_SIZE = 6'd52;
   localparam logic [5:0] LOW_LIMIT = 6'(LOW_WATER);

   logic [0:0] state_q, state_d;
   logic [5:0] left_q, left_d;
   logic       valid_q, valid_d;
   logic       err_q, err_d;
   logic       empty_q, low_q;
   logic [3:0] rank_q, rank_d;
   logic [1:0] suit_q, suit_d;
   logic [5:0] value_q, value_d;

   // Card offered by the source this cycle, and whether it can be taken
   logic       w_hit;
   logic [3:0] w_rank;
   logic [1:0] w_suit;
   logic       w_start;
   logic       w_take;

   function automatic logic [5:0] value_of(input logic [3:0] rank);
      if (rank == 4'd1) begin
         return 6'd11;
      end else if (rank <= 4'd10) begin
         return {2'b00, rank};
      end else begin
         return 6'd10;
      end
   endfunction

   assign w_start = (state_q == ST_IDLE) && draw_req && (left_q != 6'd0) && !shuffle;
   assign w_take  = (state_q == ST_SCAN) && w_hit && !shuffle;

`ifdef CARD_DECK_FIXED_SEQ_EN

   logic [3:0] ptr_q, ptr_d;

   function automatic logic [3:0] rom_rank(input logic [3:0] p);
      case (p)
         4'd0:    return 4'd10;
         4'd1:    return 4'd8;
         4'd2:    return 4'd4;
         4'd3:    return 4'd10;
         4'd4:    return 4'd8;
         4'd5:    return 4'd2;
         4'd6:    return 4'd10;
         4'd7:    return 4'd1;
         4'd8:    return 4'd10;
         4'd9:    return 4'd10;
         4'd10:   return 4'd8;
         4'd11:   return 4'd4;
         4'd12:   return 4'd8;
         4'd13:   return 4'd2;
         4'd14:   return 4'd13;
         default: return 4'd7;
      endcase
   endfunction

   assign w_hit  = 1'b1;
   assign w_rank = rom_rank(ptr_q);
   assign w_suit = 2'd0;

   always_comb begin
      ptr_d = ptr_q;
      if (shuffle) begin
         ptr_d = 4'd0;
      end else if (w_take) begin
         ptr_d = ptr_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= 4'd0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

`else

   localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] lfsr_q, lfsr_d;
   logic [51:0] used_q, used_d;
   logic [5:0]  idx_q, idx_d;
   logic [51:0] w_sel;
   logic [5:0]  w_start_idx;
   logic [5:0]  w_base;

   assign w_sel       = 52'd1 << idx_q;
   assign w_hit       = ~|(used_q & w_sel);
   assign w_start_idx = (lfsr_q[5:0] >= DECK_SIZE) ? (lfsr_q[5:0] - DECK_SIZE) : lfsr_q[5:0];

   // idx = 13*suit + (rank-1)
   always_comb begin
      if (idx_q >= 6'd39) begin
         w_suit = 2'd3;
         w_base = 6'd39;
      end else if (idx_q >= 6'd26) begin
         w_suit = 2'd2;
         w_base = 6'd26;
      end else if (idx_q >= 6'd13) begin
         w_suit = 2'd1;
         w_base = 6'd13;
      end else begin
         w_suit = 2'd0;
         w_base = 6'd0;
      end
      w_rank = 4'(idx_q - w_base) + 4'd1;
   end

   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      used_d = used_q;
      idx_d  = idx_q;
      if (shuffle) begin
         used_d = '0;
      end else if (w_start) begin
         idx_d = w_start_idx;
      end else if (w_take) begin
         used_d = used_q | w_sel;
      end else if (state_q == ST_SCAN) begin
         idx_d = (idx_q == 6'd51) ? 6'd0 : (idx_q + 6'd1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_q <= SEED_SAFE;
         used_q <= '0;
         idx_q  <= 6'd0;
      end else begin
         lfsr_q <= lfsr_d;
         used_q <= used_d;
         idx_q  <= idx_d;
      end
   end

`endif

   always_comb begin
      state_d = state_q;
      left_d  = left_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      rank_d  = rank_q;
      suit_d  = suit_q;
      value_d = value_q;
      if (shuffle) begin
         state_d = ST_IDLE;
         left_d  = DECK_SIZE;
      end else if (w_start) begin
         state_d = ST_SCAN;
      end else if ((state_q == ST_IDLE) && draw_req) begin
         err_d = 1'b1;
      end else if (w_take) begin
         state_d = ST_IDLE;
         left_d  = left_q - 6'd1;
         valid_d = 1'b1;
         rank_d  = w_rank;
         suit_d  = w_suit;
         value_d = value_of(w_rank);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         left_q  <= DECK_SIZE;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         empty_q <= 1'b0;
         low_q   <= 1'b0;
         rank_q  <= 4'd0;
         suit_q  <= 2'd0;
         value_q <= 6'd0;
      end else begin
         state_q <= state_d;
         left_q  <= left_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         empty_q <= (left_d == 6'd0);
         low_q   <= (left_d <= LOW_LIMIT);
         rank_q  <= rank_d;
         suit_q  <= suit_d;
         value_q <= value_d;
      end
   end

   assign busy       = (state_q == ST_SCAN);
   assign card_valid = valid_q;
   assign card_value = value_q;
   assign card_rank  = rank_q;
   assign card_suit  = suit_q;
   assign cards_left = left_q;
   assign deck_empty = empty_q;
   assign low_cards  = low_q;
   assign draw_err   = err_q;

endmodule
`default_nettype wire
